// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared constants for the SPI register-access master:
//                command opcodes and controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Command opcodes sent in the first byte of every transaction
    localparam logic [7:0] CMD_WRITE   = 8'h02;
    localparam logic [7:0] CMD_READ    = 8'h03;

    // Controller state encoding
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SETUP = 3'd1;
    localparam logic [2:0] c_ST_CMD   = 3'd2;
    localparam logic [2:0] c_ST_ADDR  = 3'd3;
    localparam logic [2:0] c_ST_DATA  = 3'd4;
    localparam logic [2:0] c_ST_HOLD  = 3'd5;
    localparam logic [2:0] c_ST_GAP   = 3'd6;

endpackage
`default_nettype wire

// File: rtl/spi_master_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_shifter
//  Description : SPI mode-0 bit engine. Divides the system clock into SCLK
//                half-periods, shifts one byte out MSB first, samples MISO on
//                each SCLK rise and flags the final edge of the byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_shifter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_DIV    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic                  i_stop,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_miso,
    output logic                  o_sclk,
    output logic                  o_mosi,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_done,
    output logic                  o_byte_end
);

    localparam int unsigned          c_BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_BIT_W-1:0]   c_LAST_BIT = c_BIT_W'(DATA_WIDTH - 1);
    localparam logic [7:0]           c_DIV_LAST = 8'(CLK_DIV - 1);

    logic                  r_active;
    logic                  r_phase;      // 0: SCLK low half, 1: SCLK high half
    logic [7:0]            r_div_cnt;
    logic [c_BIT_W-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic                  r_sclk;
    logic                  r_mosi;
    logic                  r_rx_done;

    logic w_div_end;
    logic w_last_bit;

    assign w_div_end  = (r_div_cnt == c_DIV_LAST);
    assign w_last_bit = (r_bit_cnt == c_LAST_BIT);

    // The final high half-period ends this cycle; the next byte may load on
    // the same edge so consecutive bytes have no dead cycles between them.
    assign o_byte_end = r_active & r_phase & w_div_end & w_last_bit;

    assign o_sclk    = r_sclk;
    assign o_mosi    = r_mosi;
    assign o_rx_data = r_rx;
    assign o_rx_done = r_rx_done;

    // Half-period divider, bit sequencing, MOSI shift-out and MISO sampling
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_active  <= 1'b0;
            r_phase   <= 1'b0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_rx_done <= 1'b0;
        end else begin
            r_rx_done <= 1'b0;
            if (i_stop) begin
                r_active  <= 1'b0;
                r_phase   <= 1'b0;
                r_div_cnt <= '0;
                r_bit_cnt <= '0;
                r_sclk    <= 1'b0;
                r_mosi    <= 1'b0;
            end else if (i_load) begin
                r_active  <= 1'b1;
                r_phase   <= 1'b0;
                r_div_cnt <= '0;
                r_bit_cnt <= '0;
                r_sclk    <= 1'b0;
                r_mosi    <= i_data[DATA_WIDTH-1];
                r_tx      <= {i_data[DATA_WIDTH-2:0], 1'b0};
            end else if (r_active) begin
                if (!w_div_end) begin
                    r_div_cnt <= r_div_cnt + 8'd1;
                end else begin
                    r_div_cnt <= '0;
                    if (!r_phase) begin
                        // Rising SCLK: capture MISO in the same cycle
                        r_phase   <= 1'b1;
                        r_sclk    <= 1'b1;
                        r_rx      <= {r_rx[DATA_WIDTH-2:0], i_miso};
                        r_rx_done <= w_last_bit;
                    end else begin
                        // Falling SCLK: MOSI only moves while SCLK is low
                        r_phase <= 1'b0;
                        r_sclk  <= 1'b0;
                        if (w_last_bit) begin
                            // Bit counter holds at the end of the byte
                            r_active <= 1'b0;
                            r_mosi   <= 1'b0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_mosi    <= r_tx[DATA_WIDTH-1];
                            r_tx      <= {r_tx[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_ctrl
//  Description : SPI register-access master. Sequences chip select, command,
//                address and 1..16 data bytes, with abort and inter-frame gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDRESS_SIZE = 8,
    parameter int unsigned CLK_DIV      = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_write,
    input  logic [ADDRESS_SIZE-1:0] i_req_addr,
    input  logic [3:0]              i_req_len,
    input  logic                    i_abort,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    output logic                    o_wr_data_pop,
    output logic [DATA_WIDTH-1:0]   o_rd_data,
    output logic                    o_rd_valid,
    output logic                    o_spi_cs,
    output logic                    o_spi_sclk,
    output logic                    o_spi_mosi,
    input  logic                    i_spi_miso,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam logic [7:0] c_WAIT_LAST = 8'(CLK_DIV - 1);

    logic [2:0]              r_state;
    logic                    r_write;
    logic [ADDRESS_SIZE-1:0] r_addr;
    logic [3:0]              r_len;
    logic [3:0]              r_byte_cnt;
    logic [7:0]              r_wait_cnt;
    logic                    r_cs;
    logic                    r_done;
    logic                    r_rd_valid;
    logic [DATA_WIDTH-1:0]   r_rd_data;

    logic                    w_abort;
    logic                    w_wait_end;
    logic                    w_load;
    logic                    w_pop;
    logic [DATA_WIDTH-1:0]   w_tx_byte;
    logic                    w_byte_end;
    logic                    w_rx_done;
    logic [DATA_WIDTH-1:0]   w_rx_data;

    assign w_abort    = i_abort && (r_state != c_ST_IDLE) && (r_state != c_ST_GAP);
    assign w_wait_end = (r_wait_cnt == c_WAIT_LAST);

    assign o_req_ready   = (r_state == c_ST_IDLE);
    assign o_busy        = (r_state != c_ST_IDLE);
    assign o_spi_cs      = r_cs;
    assign o_done        = r_done;
    assign o_rd_valid    = r_rd_valid;
    assign o_rd_data     = r_rd_data;
    assign o_wr_data_pop = w_pop;

    // Select the next byte for the shifter and decide when it loads
    always_comb begin
        w_load    = 1'b0;
        w_pop     = 1'b0;
        w_tx_byte = '0;
        if (!w_abort) begin
            case (r_state)
                c_ST_SETUP: begin
                    w_load    = w_wait_end;
                    w_tx_byte = r_write ? DATA_WIDTH'(CMD_WRITE) : DATA_WIDTH'(CMD_READ);
                end
                c_ST_CMD: begin
                    w_load    = w_byte_end;
                    w_tx_byte = DATA_WIDTH'(r_addr);
                end
                c_ST_ADDR, c_ST_DATA: begin
                    w_load    = w_byte_end &&
                                ((r_state == c_ST_ADDR) || (r_byte_cnt != r_len));
                    w_pop     = w_load && r_write;
                    w_tx_byte = r_write ? i_wr_data : '0;
                end
                default: begin
                    w_load = 1'b0;
                end
            endcase
        end
    end

    spi_master_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .CLK_DIV    (CLK_DIV)
    ) u_shifter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_stop     (w_abort),
        .i_data     (w_tx_byte),
        .i_miso     (i_spi_miso),
        .o_sclk     (o_spi_sclk),
        .o_mosi     (o_spi_mosi),
        .o_rx_data  (w_rx_data),
        .o_rx_done  (w_rx_done),
        .o_byte_end (w_byte_end)
    );

    // Transaction FSM, request capture, phase counters and status pulses
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= c_ST_IDLE;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_len      <= '0;
            r_byte_cnt <= '0;
            r_wait_cnt <= '0;
            r_cs       <= 1'b1;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            if (w_abort) begin
                r_state    <= c_ST_GAP;
                r_cs       <= 1'b1;
                r_wait_cnt <= '0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (i_req_valid) begin
                            r_state    <= c_ST_SETUP;
                            r_cs       <= 1'b0;
                            r_write    <= i_req_write;
                            r_addr     <= i_req_addr;
                            r_len      <= i_req_len;
                            r_byte_cnt <= '0;
                            r_wait_cnt <= '0;
                        end
                    end
                    c_ST_SETUP: begin
                        if (w_wait_end) begin
                            r_state    <= c_ST_CMD;
                            r_wait_cnt <= '0;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 8'd1;
                        end
                    end
                    c_ST_CMD: begin
                        if (w_byte_end) r_state <= c_ST_ADDR;
                    end
                    c_ST_ADDR: begin
                        if (w_byte_end) begin
                            r_state    <= c_ST_DATA;
                            r_byte_cnt <= '0;
                        end
                    end
                    c_ST_DATA: begin
                        if (w_rx_done && !r_write) begin
                            r_rd_valid <= 1'b1;
                            r_rd_data  <= w_rx_data;
                        end
                        if (w_byte_end) begin
                            if (r_byte_cnt == r_len) begin
                                // Byte counter holds; no wrap into another byte
                                r_state    <= c_ST_HOLD;
                                r_wait_cnt <= '0;
                            end else begin
                                r_byte_cnt <= r_byte_cnt + 4'd1;
                            end
                        end
                    end
                    c_ST_HOLD: begin
                        if (w_wait_end) begin
                            r_state    <= c_ST_GAP;
                            r_cs       <= 1'b1;
                            r_done     <= 1'b1;
                            r_wait_cnt <= '0;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 8'd1;
                        end
                    end
                    c_ST_GAP: begin
                        if (w_wait_end) begin
                            r_state    <= c_ST_IDLE;
                            r_wait_cnt <= '0;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 8'd1;
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                        r_cs    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master_ctrl
//  Description : Directed self-checking bench for spi_master_ctrl with a
//                mode-0 SPI slave model and MOSI/strobe monitors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_ctrl;

    localparam int unsigned c_CLK_DIV = 2;
    localparam int          c_BUDGET  = 3000;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_req_valid = 1'b0;
    logic       i_req_write = 1'b0;
    logic [7:0] i_req_addr = '0;
    logic [3:0] i_req_len = '0;
    logic       i_abort = 1'b0;
    logic [7:0] i_wr_data;
    logic       i_spi_miso;
    logic       o_req_ready, o_wr_data_pop, o_rd_valid;
    logic [7:0] o_rd_data;
    logic       o_spi_cs, o_spi_sclk, o_spi_mosi, o_busy, o_done;

    int n_checks = 0;
    int n_errors = 0;

    // Write data supplied in pop order across the whole run
    logic [7:0] wr_bytes [8];
    int         wr_idx = 0;
    logic       pop_prev = 1'b0;

    // MISO slave model: three bytes following the command and address
    logic [23:0] miso_stream = 24'h112233;
    int          rise_cnt = 0;

    // Monitors
    logic [7:0] mosi_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] mosi_sh = '0;
    int         mosi_bits = 0;
    int         pop_cnt = 0, done_cnt = 0, cs_falls = 0;
    int         low_run = 0, high_run = 0, last_low = 0, last_high = 0;
    logic       cs_prev = 1'b1;

    always #5 i_clk = ~i_clk;

    spi_master_ctrl #(
        .DATA_WIDTH   (8),
        .ADDRESS_SIZE (8),
        .CLK_DIV      (c_CLK_DIV)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_write   (i_req_write),
        .i_req_addr    (i_req_addr),
        .i_req_len     (i_req_len),
        .i_abort       (i_abort),
        .i_wr_data     (i_wr_data),
        .o_wr_data_pop (o_wr_data_pop),
        .o_rd_data     (o_rd_data),
        .o_rd_valid    (o_rd_valid),
        .o_spi_cs      (o_spi_cs),
        .o_spi_sclk    (o_spi_sclk),
        .o_spi_mosi    (o_spi_mosi),
        .i_spi_miso    (i_spi_miso),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    assign i_wr_data = (wr_idx < 8) ? wr_bytes[wr_idx] : 8'h00;

    // Slave drives the next MISO bit right after each SCLK rise
    always_comb begin
        int idx;
        idx        = rise_cnt - 16;
        i_spi_miso = 1'b0;
        if (rise_cnt >= 16 && idx < 24) i_spi_miso = miso_stream[23 - idx];
    end

    // SCLK-edge monitor: frame restart on CS fall, MOSI byte assembly on rise
    always @(posedge o_spi_sclk or negedge o_spi_cs) begin
        if (!o_spi_sclk) begin
            rise_cnt  = 0;
            mosi_bits = 0;
        end else begin
            rise_cnt++;
            mosi_sh = {mosi_sh[6:0], o_spi_mosi};
            mosi_bits++;
            if (mosi_bits == 8) begin
                mosi_q.push_back(mosi_sh);
                mosi_bits = 0;
            end
        end
    end

    // Cycle monitor: strobes, write-data advance and CS run lengths
    always @(negedge i_clk) begin
        if (pop_prev) wr_idx++;
        pop_prev = o_wr_data_pop;
        if (o_wr_data_pop) pop_cnt++;
        if (o_done) done_cnt++;
        if (o_rd_valid) rd_q.push_back(o_rd_data);
        if (!o_spi_cs) begin
            if (cs_prev) begin
                last_high = high_run;
                cs_falls++;
                low_run = 0;
            end
            low_run++;
        end else begin
            if (!cs_prev) begin
                last_low = low_run;
                high_run = 0;
            end
            high_run++;
        end
        cs_prev = o_spi_cs;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_mosi(input string tag, input int base, input int n, input logic [63:0] exp);
        logic [63:0] got;
        check({tag, "_nbytes"}, 64'(mosi_q.size() - base), 64'(n));
        for (int i = 0; i < n; i++) begin
            got = (base + i < mosi_q.size()) ? 64'(mosi_q[base + i]) : 64'hFFFF;
            check($sformatf("%s_byte%0d", tag, i), got, 64'(exp[8*(n-1-i) +: 8]));
        end
    endtask

    task automatic do_req(input logic wr, input logic [7:0] addr, input logic [3:0] len);
        i_req_write = wr;
        i_req_addr  = addr;
        i_req_len   = len;
        i_req_valid = 1'b1;
        @(negedge i_clk);
        i_req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (o_busy && n < c_BUDGET) begin
            @(negedge i_clk);
            n++;
        end
        check({tag, "_idle"}, 64'(o_busy), 64'd0);
    endtask

    task automatic wait_bit(input string tag, input int target);
        int n = 0;
        while (!(rise_cnt == target && !o_spi_sclk) && n < c_BUDGET) begin
            @(negedge i_clk);
            n++;
        end
        check({tag, "_reach"}, 64'(n < c_BUDGET), 64'd1);
    endtask

    initial begin
        int mb, pb, db, cb;
        wr_bytes = '{8'hA5, 8'h5A, 8'hC3, 8'h96, 8'h69, 8'h3C, 8'h00, 8'h00};

        // Reset state
        repeat (3) @(negedge i_clk);
        check("rst_cs",    64'(o_spi_cs),      64'd1);
        check("rst_sclk",  64'(o_spi_sclk),    64'd0);
        check("rst_busy",  64'(o_busy),        64'd0);
        check("rst_rdv",   64'(o_rd_valid),    64'd0);
        check("rst_pop",   64'(o_wr_data_pop), 64'd0);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("rst_ready", 64'(o_req_ready),   64'd1);

        // Single-byte write
        mb = mosi_q.size(); pb = pop_cnt; db = done_cnt;
        do_req(1'b1, 8'h10, 4'd0);
        check("wr_busy", 64'(o_busy), 64'd1);
        wait_idle("wr");
        check_mosi("wr_mosi", mb, 3, 64'h0000_0000_0002_10A5);
        check("wr_cs_low", 64'(last_low), 64'd100);
        check("wr_pops",   64'(pop_cnt - pb), 64'd1);
        check("wr_done",   64'(done_cnt - db), 64'd1);

        // Three-byte read
        mb = mosi_q.size(); pb = pop_cnt; db = done_cnt;
        do_req(1'b0, 8'h20, 4'd2);
        wait_idle("rd");
        check_mosi("rd_mosi", mb, 5, 64'h0000_0003_2000_0000);
        check("rd_count", 64'(rd_q.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("rd_data%0d", i), (i < rd_q.size()) ? 64'(rd_q[i]) : 64'hFFFF,
                  64'(miso_stream[8*(2-i) +: 8]));
        check("rd_cs_low", 64'(last_low), 64'd164);
        check("rd_pops",   64'(pop_cnt - pb), 64'd0);
        check("rd_done",   64'(done_cnt - db), 64'd1);

        // Request held high across two transactions
        mb = mosi_q.size(); pb = pop_cnt; db = done_cnt; cb = cs_falls;
        i_req_write = 1'b1; i_req_addr = 8'h30; i_req_len = 4'd1; i_req_valid = 1'b1;
        begin
            int n = 0;
            while (cs_falls - cb < 2 && n < c_BUDGET) begin
                @(negedge i_clk);
                n++;
            end
            check("b2b_second", 64'(cs_falls - cb), 64'd2);
        end
        i_req_valid = 1'b0;
        wait_idle("b2b");
        check("b2b_gap_ok", 64'(last_high >= int'(c_CLK_DIV)), 64'd1);
        check_mosi("b2b_mosi", mb, 8, 64'h0230_5AC3_0230_9669);
        check("b2b_pops", 64'(pop_cnt - pb), 64'd4);
        check("b2b_done", 64'(done_cnt - db), 64'd2);

        // Abort during the address byte, bit 3
        pb = pop_cnt; db = done_cnt;
        do_req(1'b1, 8'h44, 4'd0);
        wait_bit("abt", 11);
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        check("abt_cs",    64'(o_spi_cs),    64'd1);
        check("abt_sclk",  64'(o_spi_sclk),  64'd0);
        check("abt_rdy1",  64'(o_req_ready), 64'd0);
        @(negedge i_clk);
        check("abt_rdy2",  64'(o_req_ready), 64'd0);
        @(negedge i_clk);
        check("abt_rdy3",  64'(o_req_ready), 64'd1);
        repeat (4) @(negedge i_clk);
        check("abt_done",  64'(done_cnt - db), 64'd0);
        check("abt_pops",  64'(pop_cnt - pb),  64'd0);

        // Reset during the second data byte of a read
        do_req(1'b0, 8'h55, 4'd3);
        wait_bit("mrst", 26);
        check("mrst_rd_before", 64'(o_rd_data), 64'h11);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("mrst_cs",    64'(o_spi_cs),      64'd1);
        check("mrst_sclk",  64'(o_spi_sclk),    64'd0);
        check("mrst_mosi",  64'(o_spi_mosi),    64'd0);
        check("mrst_rdata", 64'(o_rd_data),     64'd0);
        check("mrst_rdv",   64'(o_rd_valid),    64'd0);
        check("mrst_busy",  64'(o_busy),        64'd0);
        check("mrst_done",  64'(o_done),        64'd0);
        check("mrst_pop",   64'(o_wr_data_pop), 64'd0);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("mrst_ready", 64'(o_req_ready), 64'd1);
        mb = mosi_q.size(); pb = pop_cnt; db = done_cnt;
        do_req(1'b1, 8'h66, 4'd0);
        wait_idle("post");
        check_mosi("post_mosi", mb, 3, 64'h0000_0000_0002_663C);
        check("post_cs_low", 64'(last_low), 64'd100);
        check("post_done",   64'(done_cnt - db), 64'd1);
        check("post_pops",   64'(pop_cnt - pb),  64'd1);

        // Request pulsed while busy is ignored
        mb = mosi_q.size(); db = done_cnt; cb = cs_falls;
        rd_q.delete();
        do_req(1'b0, 8'h20, 4'd1);
        wait_bit("ign", 20);
        i_req_write = 1'b1; i_req_addr = 8'h77; i_req_len = 4'd0; i_req_valid = 1'b1;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        wait_idle("ign");
        repeat (10) @(negedge i_clk);
        check("ign_busy",  64'(o_busy), 64'd0);
        check("ign_frames", 64'(cs_falls - cb), 64'd1);
        check_mosi("ign_mosi", mb, 4, 64'h0000_0000_0320_0000);
        check("ign_rd_n",  64'(rd_q.size()), 64'd2);
        check("ign_rd0",   (rd_q.size() > 0) ? 64'(rd_q[0]) : 64'hFFFF, 64'h11);
        check("ign_rd1",   (rd_q.size() > 1) ? 64'(rd_q[1]) : 64'hFFFF, 64'h22);
        check("ign_done",  64'(done_cnt - db), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, byte width on SPI and data ports.
REQ-002 Parameter ADDRESS_SIZE, default 8, register address width.
REQ-003 Parameter CLK_DIV, default 2, i_clk cycles per SCLK half-period; legal range 1..255.
REQ-004 i_clk  input  1  single system clock, all logic on rising edge.
REQ-005 i_rst  input  1  synchronous reset, active low.
REQ-006 i_req_valid  input  1  transaction request.
REQ-007 o_req_ready  output  1  high only in IDLE; a request is accepted when valid & ready.
REQ-008 i_req_write  input  1  1 = write (cmd 0x02), 0 = read (cmd 0x03).
REQ-009 i_req_addr  input  ADDRESS_SIZE  start register address.
REQ-010 i_req_len  input  4  data byte count minus 1 (1..16 bytes).
REQ-011 i_abort  input  1  terminate current transaction.
REQ-012 i_wr_data  input  DATA_WIDTH  next write byte; valid in the cycle o_wr_data_pop is high.
REQ-013 o_wr_data_pop  output  1  one-cycle pulse; write byte consumed.
REQ-014 o_rd_data  output  DATA_WIDTH  received read byte.
REQ-015 o_rd_valid  output  1  one-cycle pulse qualifying o_rd_data.
REQ-016 o_spi_cs  output  1  chip select, low = active.
REQ-017 o_spi_sclk  output  1  SPI clock, mode 0 (idle low).
REQ-018 o_spi_mosi  output  1  serial out, MSB first.
REQ-019 i_spi_miso  input  1  serial in, MSB first.
REQ-020 o_busy  output  1  high in every state except IDLE.
REQ-021 o_done  output  1  one-cycle pulse on normal completion.

Function
REQ-022 States: IDLE, SETUP, CMD, ADDR, DATA, HOLD, GAP; accept moves IDLE->SETUP and captures write/addr/len.
REQ-023 SETUP: o_spi_cs low, SCLK low, CLK_DIV cycles, then CMD.
REQ-024 Each byte: 8 bits; bit presented on MOSI while SCLK low for CLK_DIV cycles, SCLK high CLK_DIV cycles; 16*CLK_DIV cycles per byte.
REQ-025 MISO sampled in the cycle SCLK rises; MOSI changes only while SCLK low.
REQ-026 CMD sends 0x02/0x03; ADDR sends captured address; DATA sends len+1 bytes, then HOLD.
REQ-027 Write: o_wr_data_pop pulses in the cycle each data byte loads into the shifter; i_wr_data sampled that cycle.
REQ-028 Read: MOSI drives 0x00 in DATA; o_rd_valid pulses one cycle after the 8th rising SCLK of each data byte; no pop.
REQ-029 HOLD: CS low, SCLK low, CLK_DIV cycles; o_done pulses on HOLD->GAP.
REQ-030 GAP: CS high, CLK_DIV cycles, then IDLE; back-to-back CS-high time always >= CLK_DIV cycles.
REQ-031 Normal CS-low duration = (2 + (3+len)*16) * CLK_DIV cycles.
REQ-032 i_abort in any busy state except GAP: next edge CS high, SCLK low, state GAP; no o_done, no further pop/rd_valid.
REQ-033 i_abort in IDLE or GAP ignored; abort and request in same IDLE cycle: request accepted.
REQ-034 Bit and byte counters saturate at end; no wrap into a new byte after final data byte.

Reset
REQ-035 i_rst low at a rising edge, in any state including mid-byte: state IDLE, o_spi_cs 1, o_spi_sclk 0, o_spi_mosi 0, o_rd_data 0, all pulses and o_busy 0, captured fields and counters 0.
REQ-036 o_req_ready is 1 in the first cycle after i_rst returns high.

Structure
REQ-037 Shared package spi_pkg holds CMD_WRITE=8'h02, CMD_READ=8'h03 and the state encoding.
REQ-038 Sub-module spi_master_shifter: SCLK divider, 8-bit shift/sample register, byte-done strobe; spi_master_ctrl holds the FSM and counters.

Verification
REQ-039 CLK_DIV=2, write addr 0x10 len 0 data 0xA5 -> MOSI 0x02,0x10,0xA5; CS low 100 cycles; one pop; one o_done.
REQ-040 Read addr 0x20 len 2, MISO model returns 0x11,0x22,0x33 -> three o_rd_valid with those values in order; MOSI data bytes 0x00.
REQ-041 i_req_valid held high for two requests -> second accepted only in IDLE after GAP; CS high >= 2 cycles between.
REQ-042 i_abort during ADDR bit 3 -> CS high next cycle, SCLK 0, no o_done, o_req_ready high after 2 GAP cycles.
REQ-043 i_rst low during second DATA byte -> all outputs at REQ-035 values next edge; fresh request afterward completes normally.
REQ-044 i_req_valid pulsed while o_busy high -> not captured; in-flight transaction bytes unchanged.
